// File: rtl/sad_min_search.sv
// sad_min_search: drives the SAD unit over NUM_CAND candidate blocks, keeps the
// smallest SAD and its candidate index, and presents the best match on a
// valid/ready result port. A per-candidate watchdog aborts the search if the
// SAD unit stops answering.
//
// Optional feature: define SAD_EARLY_EXIT_EN to add early_thresh/early_exit.
// When defined, a candidate whose SAD is <= early_thresh ends the search at once.
//
// Handshakes:
//   sad_req/sad_valid : sad_req pulses for one cycle in REQ; cand_idx stays
//                       stable until the matching one-cycle sad_valid, which is
//                       only looked at in WAIT.
//   result            : result_valid is held in DONE with stable data; the
//                       transfer happens on the cycle result_valid && result_ready.
//
// The FSM state is kept in state_q (type state_t) so checkers can bind to it.

module sad_min_search #(
  parameter int SAD_W       = 32,
  parameter int NUM_CAND    = 16,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             search_start,
  output logic             search_busy,
  output logic             sad_req,
  output logic [IDX_W-1:0] cand_idx,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad_value,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             timeout_err
`ifdef SAD_EARLY_EXIT_EN
  ,
  input  logic [SAD_W-1:0] early_thresh,
  output logic             early_exit
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Watchdog: cleared in REQ, counts WAIT cycles. The timeout fires in the WAIT
  // cycle where the count is about to reach TIMEOUT_CYC-1, so DONE is entered
  // TIMEOUT_CYC cycles after the sad_req pulse. The counter saturates.
  localparam int WDOG_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 2);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CAND - 1);

  state_t             state_q;
  state_t             state_d;
  logic [WDOG_W-1:0]  wdog_q;
  logic [SAD_W-1:0]   sad_q;
  logic               wdog_expired;
  logic               last_cand;
  logic               better;
  logic               early_hit;

  assign wdog_expired = (wdog_q == WDOG_LAST);
  assign last_cand    = (cand_idx == LAST_IDX);
  assign better       = (sad_q < best_sad);

`ifdef SAD_EARLY_EXIT_EN
  assign early_hit = (sad_q <= early_thresh);
`else
  assign early_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (search_start) begin
          state_d = REQ;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving in the timeout cycle is still accepted.
        if (sad_valid) begin
          state_d = CMP;
        end else if (wdog_expired) begin
          state_d = DONE;
        end
      end
      CMP: begin
        if (last_cand || early_hit) begin
          state_d = DONE;
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    sad_req      = (state_q == REQ);
    search_busy  = (state_q != IDLE);
    result_valid = (state_q == DONE);
  end

  // Search datapath: candidate index, watchdog, captured SAD and best match.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_idx    <= '0;
      best_sad    <= '1;
      best_idx    <= '0;
      timeout_err <= 1'b0;
      sad_q       <= '0;
      wdog_q      <= '0;
`ifdef SAD_EARLY_EXIT_EN
      early_exit  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (search_start) begin
            cand_idx    <= '0;
            best_sad    <= '1;
            best_idx    <= '0;
            timeout_err <= 1'b0;
`ifdef SAD_EARLY_EXIT_EN
            early_exit  <= 1'b0;
`endif
          end
        end
        REQ: begin
          wdog_q <= '0;
        end
        WAIT: begin
          if (wdog_q != WDOG_MAX) begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
          if (sad_valid) begin
            sad_q <= sad_value;
          end else if (wdog_expired) begin
            timeout_err <= 1'b1;
          end
        end
        CMP: begin
          // Strict compare: on a tie the earlier (lower) index is kept.
          if (better) begin
            best_sad <= sad_q;
            best_idx <= cand_idx;
          end
`ifdef SAD_EARLY_EXIT_EN
          if (early_hit) begin
            early_exit <= 1'b1;
          end
`endif
          if (!last_cand && !early_hit) begin
            cand_idx <= cand_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_min_search.sv
// Self-checking bench for sad_min_search (NUM_CAND=4, TIMEOUT_CYC=8).
// Directed vectors come from a table with hand-derived expectations; random
// searches are checked against a min/first-index reference model.

module tb_sad_min_search;

  localparam int SAD_W = 32;
  localparam int NC    = 4;
  localparam int IW    = 2;
  localparam int TO    = 8;
  localparam int W     = 1 + IW + SAD_W;
  localparam int BUDGET = 200;
`ifdef SAD_EARLY_EXIT_EN
  localparam bit EE_EN = 1'b1;
`else
  localparam bit EE_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             search_start = 1'b0;
  logic             search_busy;
  logic             sad_req;
  logic [IW-1:0]    cand_idx;
  logic             sad_valid = 1'b0;
  logic [SAD_W-1:0] sad_value = '0;
  logic [SAD_W-1:0] best_sad;
  logic [IW-1:0]    best_idx;
  logic             result_valid;
  logic             result_ready = 1'b0;
  logic             timeout_err;
`ifdef SAD_EARLY_EXIT_EN
  logic [SAD_W-1:0] early_thresh = '0;
  logic             early_exit;
`endif

  always #5 clk = ~clk;

  sad_min_search #(
    .SAD_W(SAD_W), .NUM_CAND(NC), .IDX_W(IW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .search_start(search_start), .search_busy(search_busy),
    .sad_req(sad_req), .cand_idx(cand_idx), .sad_valid(sad_valid), .sad_value(sad_value),
    .best_sad(best_sad), .best_idx(best_idx), .result_valid(result_valid),
    .result_ready(result_ready), .timeout_err(timeout_err)
`ifdef SAD_EARLY_EXIT_EN
    , .early_thresh(early_thresh), .early_exit(early_exit)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- current search setup ----------------
  logic [SAD_W-1:0] cur_sad[NC];
  int               cur_dly[NC];
  int               cur_hang;
  int               cur_rdy;
  logic [SAD_W-1:0] thr = '0;

  typedef struct {
    logic [NC-1:0][SAD_W-1:0] sad;
    logic [NC-1:0][7:0]       dly;
    int                       hang;
    int                       rdy;
    logic [SAD_W-1:0]         exp_sad;
    logic [IW-1:0]            exp_idx;
    logic                     exp_to;
    int                       exp_reqs;
  } vec_t;

  function automatic vec_t mk(input logic [SAD_W-1:0] s0, s1, s2, s3,
                              input int d0, d1, d2, d3, hang, rdy,
                              input logic [SAD_W-1:0] es, input int ei,
                              input logic et, input int er);
    vec_t v;
    v.sad[0] = s0; v.sad[1] = s1; v.sad[2] = s2; v.sad[3] = s3;
    v.dly[0] = 8'(d0); v.dly[1] = 8'(d1); v.dly[2] = 8'(d2); v.dly[3] = 8'(d3);
    v.hang = hang; v.rdy = rdy;
    v.exp_sad = es; v.exp_idx = IW'(ei); v.exp_to = et; v.exp_reqs = er;
    return v;
  endfunction

  // Reference: the answered candidates form a prefix (cut by a hang or an early
  // exit); the result is the minimum of that prefix and the first index holding it.
  task automatic model(output logic [W-1:0] exp, output int nreq, output bit ee);
    logic [SAD_W-1:0] seen[$];
    logic [SAD_W-1:0] mn;
    int               idx;
    bit               to;
    to = 1'b0; ee = 1'b0; nreq = 0;
    for (int i = 0; i < NC; i++) begin
      nreq = i + 1;
      if (i == cur_hang) begin
        to = 1'b1;
        break;
      end
      seen.push_back(cur_sad[i]);
      if (EE_EN && cur_sad[i] <= thr) begin
        ee = 1'b1;
        break;
      end
    end
    mn = '1;
    foreach (seen[i]) if (seen[i] < mn) mn = seen[i];
    idx = 0;
    for (int i = seen.size() - 1; i >= 0; i--) if (seen[i] == mn) idx = i;
    exp = {to, IW'(idx), mn};
  endtask

  // ---------------- driver: one full search plus result handshake ----------------
  task automatic run_search(input logic [W-1:0] exp, input int exp_reqs, input bit exp_ee);
    int cyc, reqs, cnt, cur, req_cyc, last_valid_cyc, first_req_cyc;
    bit pend;
    logic [W-1:0] want;
    exp_q.push_back(exp);
`ifdef SAD_EARLY_EXIT_EN
    early_thresh = thr;
`endif
    search_start = 1'b1;
    tick();
    search_start = 1'b0;
    cyc = 0; reqs = 0; cnt = 0; cur = 0; pend = 1'b0;
    req_cyc = 0; last_valid_cyc = 0; first_req_cyc = -1;
    while (!result_valid && cyc < BUDGET) begin
      sad_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          sad_valid = 1'b1;
          sad_value = cur_sad[cur];
          pend = 1'b0;
          last_valid_cyc = cyc;
          chk("cand_idx_stable", cand_idx, cur);
        end
      end
      if (sad_req) begin
        chk("req_cand_idx", cand_idx, reqs);
        if (reqs == 0) first_req_cyc = cyc;
        cur = reqs;
        req_cyc = cyc;
        reqs++;
        if (cur != cur_hang) begin
          pend = 1'b1;
          cnt = cur_dly[cur];
        end
      end
      tick();
      cyc++;
    end
    sad_valid = 1'b0;
    chk("result_seen", result_valid, 1);
    chk("first_req_latency", first_req_cyc, 0);
    chk("req_count", reqs, exp_reqs);
    if (exp[W-1]) chk("timeout_latency", cyc - req_cyc, TO);
    else          chk("done_latency", cyc - last_valid_cyc, 2);
    want = exp_q.pop_front();
    chk("result", {timeout_err, best_idx, best_sad}, want);
`ifdef SAD_EARLY_EXIT_EN
    chk("early_exit", early_exit, exp_ee);
`else
    if (exp_ee) chk("early_exit_unexpected", exp_ee, 0);
`endif
    // Hold ready low; a stray sad_valid and a search_start pulse must be ignored.
    for (int i = 0; i < cur_rdy; i++) begin
      if (i == 1) begin
        sad_valid = 1'b1;
        sad_value = '0;
      end
      if (i == cur_rdy / 2) search_start = 1'b1;
      tick();
      sad_valid = 1'b0;
      search_start = 1'b0;
      chk("hold_outputs", {result_valid, timeout_err, best_idx, best_sad}, {1'b1, want});
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("handshake_valid_drop", result_valid, 0);
    chk("handshake_idle", search_busy, 0);
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < NC; i++) begin
      cur_sad[i] = v.sad[i];
      cur_dly[i] = int'(v.dly[i]);
    end
    cur_hang = v.hang;
    cur_rdy  = v.rdy;
  endtask

  // ---------------- test sequence ----------------
  vec_t vt[6];

  initial begin
    logic [W-1:0] e;
    int           nr;
    bit           ee;

    vt[0] = mk(500, 120, 300, 120, 3, 3, 3, 3, -1, 0, 120, 1, 0, 4);
    vt[1] = mk('1, '1, '1, '1, 1, 2, 1, 5, -1, 2, '1, 0, 0, 4);
    vt[2] = mk(7, 7, 9, 3, 2, 1, 1, 4, -1, 10, 3, 3, 0, 4);
    vt[3] = mk(40, 30, 11, 5, 3, 3, 3, 3, 2, 4, 30, 1, 1, 3);
    vt[4] = mk(5, 5, 5, 5, 1, 1, 1, 1, -1, 1, 5, 0, 0, 4);
    vt[5] = mk(1, 2, 3, 4, 1, 1, 1, 1, 0, 3, '1, 0, 1, 1);

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    chk("reset_outputs", {search_busy, sad_req, cand_idx, best_idx, result_valid, timeout_err},
        '0);
    chk("reset_best_sad", best_sad, {SAD_W{1'b1}});
    rst = 1'b0;
    tick();

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      load_vec(vt[i]);
      run_search({vt[i].exp_to, vt[i].exp_idx, vt[i].exp_sad}, vt[i].exp_reqs, 1'b0);
      tick();
    end

    // Reset while waiting on candidate 1.
    search_start = 1'b1;
    tick();
    search_start = 1'b0;
    chk("rst_seq_req0", sad_req, 1);
    tick();
    sad_valid = 1'b1;
    sad_value = 9;
    tick();
    sad_valid = 1'b0;
    tick();
    chk("rst_seq_req1", {sad_req, cand_idx}, {1'b1, 2'd1});
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy_valid_req", {search_busy, result_valid, sad_req, cand_idx, best_idx}, '0);
    chk("rst_mid_best_sad", best_sad, {SAD_W{1'b1}});
    tick();
    load_vec(vt[0]);
    run_search({vt[0].exp_to, vt[0].exp_idx, vt[0].exp_sad}, vt[0].exp_reqs, 1'b0);
    tick();

`ifdef SAD_EARLY_EXIT_EN
    // Early exit at candidate 1.
    thr = 50;
    load_vec(mk(90, 45, 10, 5, 2, 2, 2, 2, -1, 2, 45, 1, 0, 2));
    run_search({1'b0, 2'd1, 32'd45}, 2, 1'b1);
    tick();
    thr = '0;
`endif

    // Randomized searches against the reference model.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NC; i++) begin
        cur_sad[i] = ($urandom_range(0, 7) == 0) ? '1 : SAD_W'($urandom_range(1, 12));
        cur_dly[i] = $urandom_range(1, 4);
      end
      cur_hang = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NC - 1) : -1;
      cur_rdy  = $urandom_range(0, 4);
      thr      = EE_EN ? SAD_W'($urandom_range(0, 4)) : '0;
      model(e, nr, ee);
      run_search(e, nr, ee);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sad_min_search.md
Name: sad_min_search

Overview:
- Downstream consumer of the SAD datapath/controller pair in the motion-estimation path.
- Sequences the SAD unit over NUM_CAND candidate blocks:
  - issues one SAD request per candidate;
  - captures each finished SAD;
  - tracks the minimum SAD and its candidate index.
- Presents the best match on a valid/ready result port.
- Includes a per-candidate watchdog against a hung SAD unit.

Parameters:
SAD_W, 32, width of SAD value (matches the SAD result register)
NUM_CAND, 16, candidates per search (>=2)
IDX_W, 4, candidate index width, >= clog2(NUM_CAND)
TIMEOUT_CYC, 1024, max cycles waiting for one SAD result

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
search_start  input  1  pulse; begins a search; honoured only in IDLE
search_busy  output  1  high in any state except IDLE
sad_req  output  1  one-cycle pulse; tells the SAD controller to compute the candidate at cand_idx
cand_idx  output  IDX_W  current candidate; selects the B block base address; stable from sad_req until sad_valid
sad_valid  input  1  one-cycle pulse from the SAD controller; sad_value is valid
sad_value  input  SAD_W  finished SAD
best_sad  output  SAD_W  minimum SAD found; valid when result_valid
best_idx  output  IDX_W  candidate index of best_sad
result_valid  output  1  result available; held until accepted
result_ready  input  1  consumer accepts the result when result_valid&&result_ready
timeout_err  output  1  search aborted by watchdog; qualifies the result

Behaviour:
- Reset values: state=IDLE; all outputs 0, except best_sad=all ones. Reset mid-search aborts immediately; no sad_req issued in the reset cycle.
- FSM states: IDLE, REQ, WAIT, CMP, DONE.
- IDLE:
  - On search_start: cand_idx<=0, best_sad<=all ones, best_idx<=0, timeout_err<=0; go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - sad_req=1 for exactly this cycle.
  - Watchdog counter cleared.
  - Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On sad_valid: sad_q<=sad_value; go to CMP.
  - Else, if counter reaches TIMEOUT_CYC-1: timeout_err<=1; go to DONE. best_sad/best_idx keep the values from completed candidates.
  - sad_valid and timeout on the same cycle: sad_valid wins.
- CMP:
  - Update rule: if sad_q < best_sad (strict, unsigned), best_sad<=sad_q and best_idx<=cand_idx. Ties keep the earlier, lower index.
  - If cand_idx==NUM_CAND-1: go to DONE.
  - Else: cand_idx<=cand_idx+1; go to REQ.
- DONE:
  - result_valid=1; best_sad, best_idx and timeout_err held stable.
  - On result_valid&&result_ready: go to IDLE, result_valid drops the next cycle.
  - cand_idx holds its last value in DONE and IDLE.
- Ignored inputs:
  - search_start outside IDLE is ignored, including in DONE; no queuing.
  - sad_valid outside WAIT is ignored.
- Latency:
  - search_start (cycle 0) -> first sad_req in cycle 1.
  - Per candidate: 1 (REQ) + k (WAIT, k>=1) + 1 (CMP).
  - Last CMP -> result_valid the next cycle.
- Wrap: cand_idx never exceeds NUM_CAND-1. The watchdog counter saturates and does not wrap.

Optional Feature:
SAD_EARLY_EXIT_EN
- When defined:
  - Extra ports: early_thresh input SAD_W, and early_exit output 1 (reset 0, cleared at search_start).
  - In CMP, after the normal update: if sad_q <= early_thresh, set early_exit<=1 and go straight to DONE, skipping the remaining candidates.
  - Exit candidate ties with the previous best: the earlier index is kept.
- When not defined:
  - Neither port exists.
  - All NUM_CAND candidates are always scanned.

Test Plan:
- NUM_CAND=4, SAD results 500,120,300,120 (sad_valid 3 cycles after each sad_req) -> sad_req pulses with cand_idx 0,1,2,3; result_valid with best_sad=120, best_idx=1, timeout_err=0.
- All SADs = 0xFFFFFFFF -> best_sad=0xFFFFFFFF, best_idx=0 (strict compare never updates).
- result_ready held low 10 cycles in DONE, with a search_start pulse inserted -> outputs stable; no new search; return to IDLE only after the ready handshake.
- Candidate 2 never answers, TIMEOUT_CYC=8, earlier SADs 40,30 -> DONE 8 cycles after sad_req; timeout_err=1, best_sad=30, best_idx=1; stray sad_valid afterwards ignored.
- rst asserted while in WAIT for candidate 1 -> next cycle IDLE, search_busy=0, result_valid=0, best_sad=all ones; a fresh search completes normally.
- SAD_EARLY_EXIT_EN: early_thresh=50, SADs 90,45,10,... -> DONE after candidate 1; best_sad=45, best_idx=1, early_exit=1, only 2 sad_req pulses.
